// File: rtl/conv_window_buffer_mc_if.sv
// Stream bundle for conv_window_buffer_mc: raster pixel input side and NxN window output side.
interface conv_window_buffer_mc_if #(
    parameter int N           = 3,
    parameter int BitSize     = 4,
    parameter int ImageWidth  = 4,
    parameter int ImageHeight = 4,
    parameter int Channels    = 1
);
    logic                                           in_valid;
    logic                                           in_ready;
    logic [Channels-1:0][BitSize-1:0]               in_data;
    logic                                           out_valid;
    logic                                           out_ready;
    logic [Channels-1:0][N-1:0][N-1:0][BitSize-1:0] out_data;
    logic [$clog2(ImageHeight)-1:0]                 out_row;
    logic [$clog2(ImageWidth)-1:0]                  out_col;
    logic                                           out_done;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, out_row, out_col, out_done);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, out_row, out_col, out_done);
endinterface

// File: rtl/conv_window_buffer_mc.sv
// Streaming multi-channel NxN window buffer with ready/valid, stride and zero "same" padding.
// Define CONV_WBUF_VALID_EN for "valid" mode: interior centres only, no padding, no FLUSH state.
module conv_window_buffer_mc #(
    parameter int N           = 3,
    parameter int BitSize     = 4,
    parameter int ImageWidth  = 4,
    parameter int ImageHeight = 4,
    parameter int Channels    = 1,
    parameter int Stride      = 1
) (
    input logic                    clk,
    input logic                    res,
    conv_window_buffer_mc_if.slave bus
);
    localparam int P   = (N - 1) / 2;
    localparam int D   = P * ImageWidth + P;
    localparam int PIX = ImageWidth * ImageHeight;
    localparam int CW  = $clog2(PIX + D + 1);
    localparam int RW  = $clog2(ImageHeight);
    localparam int XW  = $clog2(ImageWidth);
`ifdef CONV_WBUF_VALID_EN
    localparam int LAST_R = P + ((ImageHeight - 1 - 2 * P) / Stride) * Stride;
    localparam int LAST_C = P + ((ImageWidth - 1 - 2 * P) / Stride) * Stride;
`else
    localparam int LAST_R = ((ImageHeight - 1) / Stride) * Stride;
    localparam int LAST_C = ((ImageWidth - 1) / Stride) * Stride;
    localparam logic [CW-1:0] TOTAL_C = CW'(PIX + D);
    localparam logic [CW-1:0] PIX_END = CW'(PIX - 1);
`endif
    localparam logic [CW-1:0] D_C      = CW'(D);
    localparam logic [CW-1:0] FILL_END = CW'(D - 1);
    localparam logic [CW-1:0] PIX_C    = CW'(PIX);
    localparam logic [RW-1:0] ROW_MAX  = RW'(ImageHeight - 1);
    localparam logic [XW-1:0] COL_MAX  = XW'(ImageWidth - 1);
    localparam logic [RW-1:0] LAST_R_C = RW'(LAST_R);
    localparam logic [XW-1:0] LAST_C_C = XW'(LAST_C);

    typedef logic [BitSize-1:0] pix_t;
    typedef logic [Channels-1:0][N-1:0][N-1:0][BitSize-1:0] win_t;
`ifdef CONV_WBUF_VALID_EN
    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
`else
    typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;
`endif

    // Stride grid test for a centre coordinate along one axis.
    function automatic logic on_grid(input int pos, input int extent);
`ifdef CONV_WBUF_VALID_EN
        return (pos >= P) && (pos < extent - P) && ((pos - P) % Stride == 0);
`else
        return (pos < extent) && (pos % Stride == 0);
`endif
    endfunction

    function automatic logic in_frame(input int pos, input int extent);
        return (pos >= 0) && (pos < extent);
    endfunction

    state_t        state, state_nx;
    logic [CW-1:0] in_cnt;
    logic [XW-1:0] in_col;
    logic [RW-1:0] cen_r;
    logic [XW-1:0] cen_c;
    logic          last_taken;
    logic          out_valid, out_done;
    logic [RW-1:0] out_row;
    logic [XW-1:0] out_col;

    pix_t line_buf [Channels][N-1][ImageWidth];
    pix_t win      [Channels][N][N];
    pix_t tap      [Channels][N];
    win_t masked;

    logic shift_ok, in_ready_w, in_hs, zero_shift, shift;
    logic centre_live, emit, done_hs, frame_end;

    always_comb begin
        shift_ok    = !out_valid || bus.out_ready;
        in_ready_w  = !res && (in_cnt < PIX_C) && shift_ok;
`ifdef CONV_WBUF_VALID_EN
        zero_shift  = 1'b0;
`else
        if (state == FLUSH) in_ready_w = 1'b0;
        zero_shift  = (state == FLUSH) && !last_taken && (in_cnt < TOTAL_C) && shift_ok
                      && !(out_valid && out_done);
`endif
        in_hs       = bus.in_valid && in_ready_w;
        shift       = in_hs || zero_shift;
        centre_live = in_cnt >= D_C;
        emit        = shift && centre_live
                      && on_grid(int'(cen_r), ImageHeight) && on_grid(int'(cen_c), ImageWidth);
        done_hs     = out_valid && bus.out_ready && out_done;
`ifdef CONV_WBUF_VALID_EN
        frame_end   = (state == STREAM) && (in_cnt == PIX_C) && (done_hs || last_taken);
`else
        frame_end   = (state == FLUSH) && (done_hs || last_taken);
`endif
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (in_hs) state_nx = FILL;
            FILL:   if (in_hs && in_cnt == FILL_END) state_nx = STREAM;
`ifdef CONV_WBUF_VALID_EN
            STREAM: if (frame_end) state_nx = IDLE;
`else
            STREAM: if (in_hs && in_cnt == PIX_END) state_nx = FLUSH;
            FLUSH:  if (frame_end) state_nx = IDLE;
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state      <= IDLE;
            in_cnt     <= '0;
            in_col     <= '0;
            cen_r      <= '0;
            cen_c      <= '0;
            last_taken <= 1'b0;
            out_valid  <= 1'b0;
            out_done   <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
        end else begin
            state <= state_nx;
            if (frame_end) begin
                in_cnt     <= '0;
                in_col     <= '0;
                cen_r      <= '0;
                cen_c      <= '0;
                last_taken <= 1'b0;
            end else begin
                if (done_hs) last_taken <= 1'b1;
                if (shift) begin
                    in_cnt <= in_cnt + 1'b1;
                    in_col <= (in_col == COL_MAX) ? '0 : in_col + 1'b1;
                    if (centre_live) begin
                        if (cen_c == COL_MAX) begin
                            cen_c <= '0;
                            if (cen_r != ROW_MAX) cen_r <= cen_r + 1'b1;
                        end else begin
                            cen_c <= cen_c + 1'b1;
                        end
                    end
                end
            end
            // A new window may replace the one being handed over in the same cycle.
            if (emit) begin
                out_valid <= 1'b1;
                out_row   <= cen_r;
                out_col   <= cen_c;
                out_done  <= (cen_r == LAST_R_C) && (cen_c == LAST_C_C);
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Column entering the window: N-1 buffered rows above plus the incoming pixel.
    always_comb begin
        for (int ch = 0; ch < Channels; ch++) begin
            for (int i = 0; i < N - 1; i++) tap[ch][i] = line_buf[ch][i][in_col];
            tap[ch][N-1] = zero_shift ? '0 : bus.in_data[ch];
        end
    end

    // NOTE: the line buffers are cleared by reset so no stale frame survives it; this keeps
    // them as flops rather than RAM, which is acceptable at these image widths.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int ch = 0; ch < Channels; ch++) begin
                for (int k = 0; k < N - 1; k++)
                    for (int x = 0; x < ImageWidth; x++) line_buf[ch][k][x] <= '0;
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) win[ch][i][j] <= '0;
            end
        end else if (shift) begin
            for (int ch = 0; ch < Channels; ch++) begin
                for (int k = 0; k < N - 2; k++) line_buf[ch][k][in_col] <= line_buf[ch][k+1][in_col];
                line_buf[ch][N-2][in_col] <= tap[ch][N-1];
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N - 1; j++) win[ch][i][j] <= win[ch][i][j+1];
                    win[ch][i][N-1] <= tap[ch][i];
                end
            end
        end
    end

    // Taps outside the frame, including those holding wrapped-row pixels, read as zero.
    always_comb begin
        for (int ch = 0; ch < Channels; ch++)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    masked[ch][i][j] = (out_valid
                                        && in_frame(int'(out_row) - P + i, ImageHeight)
                                        && in_frame(int'(out_col) - P + j, ImageWidth))
                                       ? win[ch][i][j] : '0;
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = masked;
    assign bus.out_row   = out_row;
    assign bus.out_col   = out_col;
    assign bus.out_done  = out_done;
endmodule

// File: tb/tb_conv_window_buffer_mc.sv
// Randomized bench for conv_window_buffer_mc: stride-1 and stride-2 instances, two channels,
// checked against a window list computed directly from the frame with zero padding.
module tb_conv_window_buffer_mc;
    localparam int N = 3, BS = 4, W = 4, H = 4, CH = 2, P = 1;
    typedef logic [CH-1:0][N-1:0][N-1:0][BS-1:0] win_t;
    typedef logic [CH-1:0][BS-1:0] px_t;
    typedef struct {
        win_t data;
        int   row;
        int   col;
        bit   done;
    } exp_t;

    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    conv_window_buffer_mc_if #(.N(N), .BitSize(BS), .ImageWidth(W), .ImageHeight(H), .Channels(CH)) bus_a ();
    conv_window_buffer_mc_if #(.N(N), .BitSize(BS), .ImageWidth(W), .ImageHeight(H), .Channels(CH)) bus_b ();

    conv_window_buffer_mc #(.N(N), .BitSize(BS), .ImageWidth(W), .ImageHeight(H), .Channels(CH), .Stride(1))
        dut_a (.clk(clk), .res(res), .bus(bus_a));
    conv_window_buffer_mc #(.N(N), .BitSize(BS), .ImageWidth(W), .ImageHeight(H), .Channels(CH), .Stride(2))
        dut_b (.clk(clk), .res(res), .bus(bus_b));

    int   sel;
    logic drv_valid, drv_ready;
    px_t  drv_data;

    assign bus_a.in_valid  = drv_valid && (sel == 0);
    assign bus_b.in_valid  = drv_valid && (sel == 1);
    assign bus_a.in_data   = drv_data;
    assign bus_b.in_data   = drv_data;
    assign bus_a.out_ready = drv_ready && (sel == 0);
    assign bus_b.out_ready = drv_ready && (sel == 1);

    logic       mon_in_ready, mon_out_valid, mon_out_done;
    win_t       mon_data;
    logic [1:0] mon_row, mon_col;
    assign mon_in_ready  = (sel == 0) ? bus_a.in_ready  : bus_b.in_ready;
    assign mon_out_valid = (sel == 0) ? bus_a.out_valid : bus_b.out_valid;
    assign mon_out_done  = (sel == 0) ? bus_a.out_done  : bus_b.out_done;
    assign mon_data      = (sel == 0) ? bus_a.out_data  : bus_b.out_data;
    assign mon_row       = (sel == 0) ? bus_a.out_row   : bus_b.out_row;
    assign mon_col       = (sel == 0) ? bus_a.out_col   : bus_b.out_col;

    int errors = 0;
    int checks = 0;
    logic [BS-1:0] fr [CH][H][W];
    exp_t exp_q [$];

    function automatic logic [BS-1:0] px_at(int ch, int r, int c);
        if (r < 0 || r >= H || c < 0 || c >= W) return '0;
        return fr[ch][r][c];
    endfunction

    // Reference: every grid centre in raster order, last one flagged done.
    task automatic build_expected(input int stride);
        int lo, hi_r, hi_c;
`ifdef CONV_WBUF_VALID_EN
        lo = P; hi_r = H - P; hi_c = W - P;
`else
        lo = 0; hi_r = H; hi_c = W;
`endif
        exp_q.delete();
        for (int r = lo; r < hi_r; r += stride)
            for (int c = lo; c < hi_c; c += stride) begin
                exp_t e;
                e.row = r; e.col = c; e.done = 1'b0;
                for (int ch = 0; ch < CH; ch++)
                    for (int i = 0; i < N; i++)
                        for (int j = 0; j < N; j++) e.data[ch][i][j] = px_at(ch, r - P + i, c - P + j);
                exp_q.push_back(e);
            end
        exp_q[exp_q.size() - 1].done = 1'b1;
    endtask

    task automatic load_directed();
        int rows [H][W] = '{'{7, 2, 2, 15}, '{8, 8, 15, 7}, '{15, 2, 8, 8}, '{15, 8, 8, 8}};
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                fr[0][r][c] = BS'(rows[r][c]);
                fr[1][r][c] = BS'(rows[r][c]) ^ 4'hF;
            end
    endtask

    task automatic load_random();
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) fr[ch][r][c] = BS'($urandom_range(15));
    endtask

    function automatic px_t pixel(int idx);
        px_t p;
        for (int ch = 0; ch < CH; ch++) p[ch] = (idx < H * W) ? fr[ch][idx / W][idx % W] : '0;
        return p;
    endfunction

    // Streams the loaded frame into the selected DUT and checks every window handed over.
    task automatic run_frame(input int vld_pct, input int rdy_pct, input bit do_bp, input string tag);
        int   pi = 0, cyc = 0, bp_left = 0;
        bit   bp_done = 0, stalled = 0;
        win_t held_d;
        logic [1:0] held_r, held_c;
        build_expected((sel == 0) ? 1 : 2);
        while (exp_q.size() > 0 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            drv_valid = (pi < H * W) && ($urandom_range(99) < vld_pct);
            drv_data  = pixel(pi);
            if (do_bp && !bp_done && mon_out_valid && mon_row == 2'd1 && mon_col == 2'd1) begin
                bp_left = 5; bp_done = 1;
            end
            if (bp_left > 0) begin
                drv_ready = 1'b0; bp_left--;
            end else begin
                drv_ready = ($urandom_range(99) < rdy_pct);
            end
            #1;
            if (stalled) begin
                checks++;
                if (mon_out_valid !== 1'b1 || mon_data !== held_d || mon_row !== held_r || mon_col !== held_c) begin
                    errors++;
                    $display("FAIL %s hold: valid=%b data=%h row=%0d col=%0d, required valid=1 data=%h row=%0d col=%0d",
                             tag, mon_out_valid, mon_data, mon_row, mon_col, held_d, held_r, held_c);
                end
            end
            if (mon_out_valid && !drv_ready) begin
                checks++;
                if (mon_in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s stall_in_ready: got %b, required 0", tag, mon_in_ready);
                end
            end
            if (drv_valid && mon_in_ready) pi++;
            if (mon_out_valid && drv_ready) begin
                exp_t e = exp_q.pop_front();
                checks++;
                if (mon_data !== e.data || int'(mon_row) != e.row || int'(mon_col) != e.col || mon_out_done !== e.done) begin
                    errors++;
                    $display("FAIL %s window: got row=%0d col=%0d done=%b data=%h, required row=%0d col=%0d done=%b data=%h",
                             tag, mon_row, mon_col, mon_out_done, mon_data, e.row, e.col, e.done, e.data);
                end
            end
            stalled = mon_out_valid && !drv_ready;
            held_d = mon_data; held_r = mon_row; held_c = mon_col;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: %0d windows outstanding, required 0", tag, exp_q.size());
        end
        @(negedge clk);
        drv_valid = 1'b0; drv_ready = 1'b1;
        #1;
        checks++;
        if (pi != H * W) begin
            errors++;
            $display("FAIL %s pixels_taken: got %0d, required %0d", tag, pi, H * W);
        end
        checks++;
        if (mon_out_valid !== 1'b0 || mon_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_after_frame: out_valid=%b in_ready=%b, required 0 and 1",
                     tag, mon_out_valid, mon_in_ready);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if ({mon_in_ready, mon_out_valid, mon_out_done, mon_row, mon_col, mon_data} !== '0) begin
            errors++;
            $display("FAIL %s: in_ready=%b out_valid=%b done=%b row=%0d col=%0d data=%h, required all 0",
                     tag, mon_in_ready, mon_out_valid, mon_out_done, mon_row, mon_col, mon_data);
        end
    endtask

    task automatic test_reset();
        res = 1'b1; sel = 0; drv_valid = 1'b1; drv_ready = 1'b1; drv_data = '0;
        repeat (3) @(negedge clk);
        #1;
        check_zero_outputs("reset_stride1");
        sel = 1;
        #1;
        check_zero_outputs("reset_stride2");
        @(negedge clk);
        res = 1'b0; drv_valid = 1'b0; sel = 0;
    endtask

    task automatic test_same_directed();
        sel = 0; load_directed();
        run_frame(100, 100, 0, "same_directed");
    endtask

    task automatic test_backpressure();
        sel = 0; load_directed();
        run_frame(100, 100, 1, "backpressure");
    endtask

    task automatic test_random();
        sel = 0;
        for (int k = 0; k < 4; k++) begin
            load_random();
            run_frame(70, 60, 0, "random");
        end
    endtask

    task automatic test_back_to_back();
        sel = 0;
        for (int k = 0; k < 3; k++) begin
            load_random();
            run_frame(100, 100, 0, "back_to_back");
        end
    endtask

    task automatic test_stride2();
        sel = 1; load_directed();
        run_frame(100, 100, 0, "stride2_directed");
        for (int k = 0; k < 3; k++) begin
            load_random();
            run_frame(75, 50, 0, "stride2_random");
        end
    endtask

    task automatic test_reset_midframe();
        int pi = 0, cyc = 0;
        sel = 0; load_directed();
        while (pi < 9 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            drv_valid = 1'b1; drv_ready = 1'b1; drv_data = pixel(pi);
            #1;
            if (mon_in_ready) pi++;
        end
        @(negedge clk);
        res = 1'b1; drv_data = pixel(pi);
        #1;
        check_zero_outputs("reset_midframe");
        @(negedge clk);
        res = 1'b0; drv_valid = 1'b0;
        run_frame(100, 100, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_same_directed();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_stride2();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
